nios2_system_sysid_check: RTL and testbench
===========================================

// Module: nios2_system_sysid_check
// PURPOSE
//  Avalon-MM read master that sits upstream of the system ID slave and consumes its readdata.
//  After reset (or on a start pulse) it reads word 0 (system ID) and word 1 (timestamp).
//  It compares both words against build-time expectations and reports pass/fail.
//  Software and the boot LED logic use it to detect a mismatched FPGA image before the CPU runs.
// PARAMETERS
//  EXPECTED_ID        32'd0           value required at address 0
//  EXPECTED_TS        32'd1619612925  value required at address 1
//  READ_LATENCY       0               cycles from accepted read to valid readdata (0..3)
//  TIMEOUT_CYCLES     255             max waitrequest stall per read before error (1..65535)
//  AUTO_START         1               1 = run one check automatically after reset release
// PORTS
//  clock          in   1   system clock
//  reset_n        in   1   asynchronous active-low reset
//  start          in   1   single-cycle pulse; begins a check when idle
//  m_address      out  1   word address to sysid slave (0 = ID, 1 = timestamp)
//  m_read         out  1   Avalon read request
//  m_waitrequest  in   1   slave stall; tie 0 for a zero-wait slave
//  m_readdata     in   32  slave read data
//  busy           out  1   check in progress
//  done           out  1   one-cycle pulse when a check completes (pass, fail or timeout)
//  id_ok          out  1   sticky: last ID read equalled EXPECTED_ID
//  ts_ok          out  1   sticky: last timestamp read equalled EXPECTED_TS
//  timeout_err    out  1   sticky: last check aborted on stall timeout
//  id_value       out  32  last captured ID word
//  ts_value       out  32  last captured timestamp word
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0; clock and reset_n as named above.
//  FSM: IDLE -> RD_ID -> WAIT_ID -> RD_TS -> WAIT_TS -> DONE -> IDLE.
//  IDLE: leave on start=1, or on first cycle after reset release if AUTO_START=1.
//  RD_x: m_read=1, m_address=0 (ID) or 1 (TS); held stable while m_waitrequest=1.
//   Command accepted on cycle with m_read & !m_waitrequest.
//  WAIT_x: count READ_LATENCY cycles, capture m_readdata into id_value/ts_value.
//   READ_LATENCY=0: capture in the accept cycle itself and skip WAIT_x.
//  Stall timer: counts cycles with m_read & m_waitrequest; reset on accept.
//   Reaching TIMEOUT_CYCLES drops m_read and sets timeout_err=1, id_ok=ts_ok=0.
//   FSM then goes to DONE; the remaining read is skipped.
//  DONE: one cycle; done=1; id_ok/ts_ok updated from 32-bit equality compares; -> IDLE.
//  busy=1 in every state except IDLE; start while busy is ignored (not queued).
//  id_ok, ts_ok and timeout_err hold until the next DONE.
//   A new check clears them only when it completes.
//  Back-to-back: start in the cycle after done begins a new check; m_read is never asserted in IDLE.
//  Reset mid-read: m_read drops asynchronously; no partial results are retained.
//  Worst-case duration: 2*(1+READ_LATENCY+TIMEOUT_CYCLES)+1 cycles.
// STRUCTURE
//  Shared package: FSM state encoding and the SYSID_ADDR_ID=0 / SYSID_ADDR_TS=1 constants.
//   The sysid slave and software header generator use the same constants.
//  Single module plus one sub-module, nios2_system_sysid_check_timer.
//   The sub-module holds the loadable stall/latency down-counter with zero flag.
// TESTING
//  1 Slave returns 0 at addr 0 and 1619612925 at addr 1, waitrequest=0, AUTO_START=1
//    -> done pulse about 4 cycles after reset release, id_ok=1, ts_ok=1, busy low after.
//  2 Timestamp read returns 32'h12345678 -> ts_value=32'h12345678, ts_ok=0, id_ok=1, timeout_err=0.
//  3 waitrequest=1 for 10 cycles on ID read, TIMEOUT_CYCLES=255
//    -> m_read/m_address held stable, check passes.
//  4 waitrequest stuck at 1 with TIMEOUT_CYCLES=16 -> m_read drops after 16 stall cycles.
//    Also done=1, timeout_err=1, id_ok=ts_ok=0.
//  5 READ_LATENCY=2, data valid only 2 cycles after accept
//    -> correct words captured; start pulsed while busy is ignored.
//  6 reset_n low during WAIT_TS -> all outputs 0 immediately; AUTO_START=0 then start pulse
//    -> fresh complete check.

Source files
------------

// File: rtl/nios2_system_sysid_check_pkg.sv
// ---------------------------------------------------------------------------
// nios2_system_sysid_check_pkg
// Shared definitions for the system-ID check master:
//   state_e        - check FSM state encoding
//   SYSID_ADDR_ID  - word address of the system ID register
//   SYSID_ADDR_TS  - word address of the build timestamp register
//   TIMER_WIDTH    - width of the stall/latency down-counter
// The sysid slave and the software header generator use the same addresses.
// ---------------------------------------------------------------------------
package nios2_system_sysid_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ID   = 3'd1,
        ST_WAIT_ID = 3'd2,
        ST_RD_TS   = 3'd3,
        ST_WAIT_TS = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam int TIMER_WIDTH = 16;

endpackage

// File: rtl/nios2_system_sysid_check_if.sv
// ---------------------------------------------------------------------------
// nios2_system_sysid_check_if
// Avalon-MM read-only link between the check master and the sysid slave.
//   m_address      1  word address (0 = ID, 1 = timestamp)
//   m_read         1  read request
//   m_waitrequest  1  slave stall
//   m_readdata     32 read data
// Modports: master (check block side), slave (sysid side).
// ---------------------------------------------------------------------------
interface nios2_system_sysid_check_if;

    logic        m_address;
    logic        m_read;
    logic        m_waitrequest;
    logic [31:0] m_readdata;

    modport master (
        output m_address,
        output m_read,
        input  m_waitrequest,
        input  m_readdata
    );

    modport slave (
        input  m_address,
        input  m_read,
        output m_waitrequest,
        output m_readdata
    );

endinterface

// File: rtl/nios2_system_sysid_check_timer.sv
// ---------------------------------------------------------------------------
// nios2_system_sysid_check_timer
// Loadable down-counter shared by the stall timeout and the read-latency
// wait. It saturates at zero so a late decrement cannot wrap around.
//   clock, reset_n  clock and asynchronous active-low reset
//   load            load load_value (has priority over dec)
//   load_value      value to load
//   dec             decrement by one when not already zero
//   zero            count is zero
// ---------------------------------------------------------------------------
module nios2_system_sysid_check_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && !zero) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/nios2_system_sysid_check.sv
// ---------------------------------------------------------------------------
// nios2_system_sysid_check
// Avalon-MM read master that reads the sysid slave (word 0 = system ID,
// word 1 = build timestamp) after reset and/or on a start pulse, and reports
// whether both words match the values this image was built against.
//   clock, reset_n  clock and asynchronous active-low reset
//   start           single-cycle pulse; begins a check when idle
//   m               Avalon-MM master port (see nios2_system_sysid_check_if)
//   busy            check in progress
//   done            one-cycle pulse when a check completes
//   id_ok, ts_ok    sticky compare results of the last completed check
//   timeout_err     sticky: last check aborted on a waitrequest stall
//   id_value        last captured ID word
//   ts_value        last captured timestamp word
// ---------------------------------------------------------------------------
module nios2_system_sysid_check
    import nios2_system_sysid_check_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1619612925,
    parameter int          READ_LATENCY   = 0,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          start,
    nios2_system_sysid_check_if.master    m,
    output logic                          busy,
    output logic                          done,
    output logic                          id_ok,
    output logic                          ts_ok,
    output logic                          timeout_err,
    output logic [31:0]                   id_value,
    output logic [31:0]                   ts_value
);

    // The timer counts down to zero, so both loads are "cycles minus one":
    // a read times out on its TIMEOUT_CYCLES-th stalled cycle, and data is
    // captured READ_LATENCY cycles after the accept cycle.
    localparam logic [TIMER_WIDTH-1:0] STALL_LOAD = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] LAT_LOAD   =
        (READ_LATENCY > 0) ? TIMER_WIDTH'(READ_LATENCY - 1) : '0;

    state_e                 state;
    state_e                 next_state;
    logic                   auto_pending;
    logic                   rd_active;
    logic                   accept;
    logic                   tmr_load;
    logic [TIMER_WIDTH-1:0] tmr_load_value;
    logic                   tmr_dec;
    logic                   tmr_zero;
    logic                   cap_id;
    logic                   cap_ts;
    logic                   finish_ok;
    logic                   finish_to;

    // ------------------------------------------------------------------
    // Bus outputs decode straight from state, so an asynchronous reset
    // drops m_read immediately and m_read can never be high in IDLE.
    // ------------------------------------------------------------------
    assign rd_active   = (state == ST_RD_ID) || (state == ST_RD_TS);
    assign m.m_read    = rd_active;
    assign m.m_address = (state == ST_RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    assign accept      = rd_active && !m.m_waitrequest;

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    // Cleared on the first clock after reset release, which is exactly the
    // cycle the IDLE state looks at it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            auto_pending <= AUTO_START;
        end else begin
            auto_pending <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every signal driven here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        next_state     = state;
        tmr_load       = 1'b0;
        tmr_load_value = STALL_LOAD;
        tmr_dec        = 1'b0;
        cap_id         = 1'b0;
        cap_ts         = 1'b0;
        finish_ok      = 1'b0;
        finish_to      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start || auto_pending) begin
                    next_state = ST_RD_ID;
                    tmr_load   = 1'b1;
                end
            end

            ST_RD_ID: begin
                if (accept) begin
                    tmr_load = 1'b1;
                    if (READ_LATENCY == 0) begin
                        cap_id     = 1'b1;
                        next_state = ST_RD_TS;
                    end else begin
                        tmr_load_value = LAT_LOAD;
                        next_state     = ST_WAIT_ID;
                    end
                end else if (tmr_zero) begin
                    finish_to  = 1'b1;
                    next_state = ST_DONE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            ST_WAIT_ID: begin
                if (tmr_zero) begin
                    cap_id     = 1'b1;
                    tmr_load   = 1'b1;
                    next_state = ST_RD_TS;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            ST_RD_TS: begin
                if (accept) begin
                    if (READ_LATENCY == 0) begin
                        cap_ts     = 1'b1;
                        finish_ok  = 1'b1;
                        next_state = ST_DONE;
                    end else begin
                        tmr_load       = 1'b1;
                        tmr_load_value = LAT_LOAD;
                        next_state     = ST_WAIT_TS;
                    end
                end else if (tmr_zero) begin
                    finish_to  = 1'b1;
                    next_state = ST_DONE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            ST_WAIT_TS: begin
                if (tmr_zero) begin
                    cap_ts     = 1'b1;
                    finish_ok  = 1'b1;
                    next_state = ST_DONE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            ST_DONE: begin
                next_state = ST_IDLE;
            end

            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    nios2_system_sysid_check_timer #(
        .WIDTH (TIMER_WIDTH)
    ) u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .dec        (tmr_dec),
        .zero       (tmr_zero)
    );

    // ------------------------------------------------------------------
    // Captured words and sticky results. Flags are written only on the
    // edge that enters DONE, so they are valid while done is high and hold
    // through the whole next check. The ID word is always captured before
    // the TS read, so comparing the id_value register here is safe; the TS
    // word is compared straight off the bus in its capture cycle.
    // ------------------------------------------------------------------
    // NOTE: the captured words are reset too, so a reset in mid-check leaves
    // no partial result visible.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            id_value    <= '0;
            ts_value    <= '0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (cap_id) begin
                id_value <= m.m_readdata;
            end
            if (cap_ts) begin
                ts_value <= m.m_readdata;
            end
            if (finish_ok) begin
                id_ok       <= (id_value == EXPECTED_ID);
                ts_ok       <= (m.m_readdata == EXPECTED_TS);
                timeout_err <= 1'b0;
            end else if (finish_to) begin
                id_ok       <= 1'b0;
                ts_ok       <= 1'b0;
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nios2_system_sysid_check.sv
// ---------------------------------------------------------------------------
// tb_nios2_system_sysid_check
// Three instances of the check master share one clock and reset:
//   dut_a  defaults (zero latency, AUTO_START=1)
//   dut_b  TIMEOUT_CYCLES=16, AUTO_START=0
//   dut_c  READ_LATENCY=2,    AUTO_START=0
// Each has a small behavioural sysid slave. Inputs are driven and outputs
// sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_nios2_system_sysid_check;

    localparam logic [31:0] EXP_ID  = 32'd0;
    localparam logic [31:0] EXP_TS  = 32'd1619612925;
    localparam logic [31:0] GARBAGE = 32'hDEAD_BEEF;

    logic clock = 1'b0;
    logic reset_n = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    // ---------------- instance A ----------------
    nios2_system_sysid_check_if if_a ();
    logic        start_a = 1'b0, wr_a = 1'b0;
    logic [31:0] id_word_a = EXP_ID, ts_word_a = EXP_TS;
    logic        busy_a, done_a, id_ok_a, ts_ok_a, to_a;
    logic [31:0] id_val_a, ts_val_a;

    assign if_a.m_waitrequest = wr_a;
    assign if_a.m_readdata    = if_a.m_read ? (if_a.m_address ? ts_word_a : id_word_a) : GARBAGE;

    nios2_system_sysid_check dut_a (
        .clock (clock), .reset_n (reset_n), .start (start_a), .m (if_a),
        .busy (busy_a), .done (done_a), .id_ok (id_ok_a), .ts_ok (ts_ok_a),
        .timeout_err (to_a), .id_value (id_val_a), .ts_value (ts_val_a)
    );

    // ---------------- instance B ----------------
    nios2_system_sysid_check_if if_b ();
    logic        start_b = 1'b0, wr_b = 1'b0;
    logic [31:0] id_word_b = EXP_ID, ts_word_b = EXP_TS;
    logic        busy_b, done_b, id_ok_b, ts_ok_b, to_b;
    logic [31:0] id_val_b, ts_val_b;

    assign if_b.m_waitrequest = wr_b;
    assign if_b.m_readdata    = if_b.m_read ? (if_b.m_address ? ts_word_b : id_word_b) : GARBAGE;

    nios2_system_sysid_check #(
        .TIMEOUT_CYCLES (16),
        .AUTO_START     (1'b0)
    ) dut_b (
        .clock (clock), .reset_n (reset_n), .start (start_b), .m (if_b),
        .busy (busy_b), .done (done_b), .id_ok (id_ok_b), .ts_ok (ts_ok_b),
        .timeout_err (to_b), .id_value (id_val_b), .ts_value (ts_val_b)
    );

    // ---------------- instance C (latency 2 slave) ----------------
    nios2_system_sysid_check_if if_c ();
    logic        start_c = 1'b0;
    logic [31:0] id_word_c = EXP_ID, ts_word_c = EXP_TS;
    logic        busy_c, done_c, id_ok_c, ts_ok_c, to_c;
    logic [31:0] id_val_c, ts_val_c;
    logic        p0_v, p0_a, p1_v, p1_a;

    // Read data is valid only in the second cycle after the accept cycle.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            p0_v <= 1'b0; p0_a <= 1'b0; p1_v <= 1'b0; p1_a <= 1'b0;
        end else begin
            p0_v <= if_c.m_read && !if_c.m_waitrequest;
            p0_a <= if_c.m_address;
            p1_v <= p0_v;
            p1_a <= p0_a;
        end
    end

    assign if_c.m_waitrequest = 1'b0;
    assign if_c.m_readdata    = p1_v ? (p1_a ? ts_word_c : id_word_c) : GARBAGE;

    nios2_system_sysid_check #(
        .READ_LATENCY (2),
        .AUTO_START   (1'b0)
    ) dut_c (
        .clock (clock), .reset_n (reset_n), .start (start_c), .m (if_c),
        .busy (busy_c), .done (done_c), .id_ok (id_ok_c), .ts_ok (ts_ok_c),
        .timeout_err (to_c), .id_value (id_val_c), .ts_value (ts_val_c)
    );

    // Waits on falling edges for done of the selected instance; cyc is the
    // number of falling edges waited, or -1 if the budget ran out.
    task automatic wait_done(input int which, input int budget, output int cyc);
        logic d;
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clock);
            case (which)
                0:       d = done_a;
                1:       d = done_b;
                default: d = done_c;
            endcase
            if (d) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        tests_run++;
        if ({busy_a, done_a, id_ok_a, ts_ok_a, to_a, if_a.m_read, if_a.m_address} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_flags_a: got %b expected 0000000",
                     {busy_a, done_a, id_ok_a, ts_ok_a, to_a, if_a.m_read, if_a.m_address});
        end
        tests_run++;
        if ({id_val_a, ts_val_a, id_val_b, ts_val_b, id_val_c, ts_val_c} !== 192'b0) begin
            tests_failed++;
            $display("FAIL reset_values: got %h %h expected 0", id_val_a, ts_val_a);
        end
        tests_run++;
        if ({busy_b, if_b.m_read, busy_c, if_c.m_read, to_b, to_c} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_flags_bc: got %b expected 000000",
                     {busy_b, if_b.m_read, busy_c, if_c.m_read, to_b, to_c});
        end
        reset_n = 1'b1;
    endtask

    task automatic test_auto_start();
        int done_cyc;
        done_cyc = -1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clock);
            if (cyc == 1) begin
                tests_run++;
                if ({if_a.m_read, if_a.m_address} !== 2'b10) begin
                    tests_failed++;
                    $display("FAIL auto_rd_id: got %b expected 10", {if_a.m_read, if_a.m_address});
                end
            end
            if (cyc == 2) begin
                tests_run++;
                if ({if_a.m_read, if_a.m_address} !== 2'b11) begin
                    tests_failed++;
                    $display("FAIL auto_rd_ts: got %b expected 11", {if_a.m_read, if_a.m_address});
                end
            end
            if (done_a) begin
                done_cyc = cyc;
                break;
            end
        end
        tests_run++;
        if (done_cyc !== 3) begin
            tests_failed++;
            $display("FAIL auto_done_latency: got %0d expected 3", done_cyc);
        end
        tests_run++;
        if ({id_ok_a, ts_ok_a, to_a} !== 3'b110) begin
            tests_failed++;
            $display("FAIL auto_flags: got %b expected 110", {id_ok_a, ts_ok_a, to_a});
        end
        tests_run++;
        if (id_val_a !== EXP_ID || ts_val_a !== EXP_TS) begin
            tests_failed++;
            $display("FAIL auto_values: got %h %h expected %h %h", id_val_a, ts_val_a, EXP_ID, EXP_TS);
        end
        @(negedge clock);
        tests_run++;
        if ({busy_a, done_a, if_a.m_read, busy_b, busy_c} !== 5'b0) begin
            tests_failed++;
            $display("FAIL auto_idle_after: got %b expected 00000",
                     {busy_a, done_a, if_a.m_read, busy_b, busy_c});
        end
    endtask

    task automatic test_ts_mismatch();
        int cyc;
        @(negedge clock);
        ts_word_a = 32'h1234_5678;
        start_a   = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        wait_done(0, 20, cyc);
        tests_run++;
        if (cyc !== 2) begin
            tests_failed++;
            $display("FAIL mismatch_done_latency: got %0d expected 2", cyc);
        end
        tests_run++;
        if (ts_val_a !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL mismatch_ts_value: got %h expected 12345678", ts_val_a);
        end
        tests_run++;
        if ({id_ok_a, ts_ok_a, to_a} !== 3'b100) begin
            tests_failed++;
            $display("FAIL mismatch_flags: got %b expected 100", {id_ok_a, ts_ok_a, to_a});
        end
        ts_word_a = EXP_TS;
    endtask

    task automatic test_wait_stall();
        int cyc;
        @(negedge clock);
        wr_a    = 1'b1;
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if ({if_a.m_read, if_a.m_address, busy_a, ts_ok_a} !== 4'b1010) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: got %b expected 1010", i,
                         {if_a.m_read, if_a.m_address, busy_a, ts_ok_a});
            end
            if (i < 9) @(negedge clock);
        end
        wr_a = 1'b0;
        wait_done(0, 300, cyc);
        tests_run++;
        if (cyc !== 2) begin
            tests_failed++;
            $display("FAIL stall_done_latency: got %0d expected 2", cyc);
        end
        tests_run++;
        if ({id_ok_a, ts_ok_a, to_a} !== 3'b110) begin
            tests_failed++;
            $display("FAIL stall_flags: got %b expected 110", {id_ok_a, ts_ok_a, to_a});
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(negedge clock);
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        wait_done(0, 20, cyc);
        tests_run++;
        if (cyc !== 2) begin
            tests_failed++;
            $display("FAIL b2b_first_done: got %0d expected 2", cyc);
        end
        @(negedge clock);
        tests_run++;
        if ({busy_a, if_a.m_read} !== 2'b00) begin
            tests_failed++;
            $display("FAIL b2b_idle_gap: got %b expected 00", {busy_a, if_a.m_read});
        end
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        tests_run++;
        if ({busy_a, if_a.m_read} !== 2'b11) begin
            tests_failed++;
            $display("FAIL b2b_restart: got %b expected 11", {busy_a, if_a.m_read});
        end
        wait_done(0, 20, cyc);
        tests_run++;
        if (cyc !== 2 || {id_ok_a, ts_ok_a, to_a} !== 3'b110) begin
            tests_failed++;
            $display("FAIL b2b_second: got %0d/%b expected 2/110", cyc, {id_ok_a, ts_ok_a, to_a});
        end
    endtask

    task automatic test_timeout();
        int cyc;
        int hi;
        @(negedge clock);
        start_b = 1'b1;
        @(negedge clock);
        start_b = 1'b0;
        wait_done(1, 20, cyc);
        tests_run++;
        if (cyc !== 2 || {id_ok_b, ts_ok_b, to_b} !== 3'b110) begin
            tests_failed++;
            $display("FAIL timeout_prerun: got %0d/%b expected 2/110", cyc, {id_ok_b, ts_ok_b, to_b});
        end
        @(negedge clock);
        wr_b    = 1'b1;
        start_b = 1'b1;
        @(negedge clock);
        start_b = 1'b0;
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            if (!if_b.m_read) break;
            hi++;
            @(negedge clock);
        end
        tests_run++;
        if (hi !== 16) begin
            tests_failed++;
            $display("FAIL timeout_stall_cycles: got %0d expected 16", hi);
        end
        tests_run++;
        if ({done_b, to_b, id_ok_b, ts_ok_b} !== 4'b1100) begin
            tests_failed++;
            $display("FAIL timeout_flags: got %b expected 1100", {done_b, to_b, id_ok_b, ts_ok_b});
        end
        wr_b = 1'b0;
        @(negedge clock);
        tests_run++;
        if ({busy_b, if_b.m_read, to_b} !== 3'b001) begin
            tests_failed++;
            $display("FAIL timeout_after: got %b expected 001", {busy_b, if_b.m_read, to_b});
        end
    endtask

    task automatic test_latency();
        int done_cyc;
        logic saw_busy;
        @(negedge clock);
        start_c  = 1'b1;
        done_cyc = -1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clock);
            if (cyc == 1) start_c = 1'b0;
            if (cyc == 3) start_c = 1'b1;
            if (cyc == 4) start_c = 1'b0;
            if (done_c) begin
                done_cyc = cyc;
                break;
            end
        end
        tests_run++;
        if (done_cyc !== 7) begin
            tests_failed++;
            $display("FAIL latency_done_cycle: got %0d expected 7", done_cyc);
        end
        tests_run++;
        if (id_val_c !== EXP_ID || ts_val_c !== EXP_TS) begin
            tests_failed++;
            $display("FAIL latency_values: got %h %h expected %h %h", id_val_c, ts_val_c, EXP_ID, EXP_TS);
        end
        tests_run++;
        if ({id_ok_c, ts_ok_c, to_c} !== 3'b110) begin
            tests_failed++;
            $display("FAIL latency_flags: got %b expected 110", {id_ok_c, ts_ok_c, to_c});
        end
        saw_busy = 1'b0;
        repeat (5) begin
            @(negedge clock);
            if (busy_c) saw_busy = 1'b1;
        end
        tests_run++;
        if (saw_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency_start_ignored: got busy=%b expected 0", saw_busy);
        end
    endtask

    task automatic test_reset_mid_read();
        int cyc;
        logic saw_busy;
        @(negedge clock);
        id_word_c = 32'h1111_2222;
        start_c   = 1'b1;
        @(negedge clock);
        start_c = 1'b0;
        repeat (4) @(negedge clock);
        tests_run++;
        if (id_val_c !== 32'h1111_2222 || busy_c !== 1'b1) begin
            tests_failed++;
            $display("FAIL midread_before: got %h/%b expected 11112222/1", id_val_c, busy_c);
        end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({busy_c, done_c, if_c.m_read, id_ok_c, ts_ok_c, to_c} !== 6'b0) begin
            tests_failed++;
            $display("FAIL midread_async_flags: got %b expected 000000",
                     {busy_c, done_c, if_c.m_read, id_ok_c, ts_ok_c, to_c});
        end
        tests_run++;
        if (id_val_c !== 32'd0 || ts_val_c !== 32'd0) begin
            tests_failed++;
            $display("FAIL midread_async_values: got %h %h expected 0 0", id_val_c, ts_val_c);
        end
        repeat (2) @(negedge clock);
        reset_n   = 1'b1;
        id_word_c = EXP_ID;
        saw_busy  = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (busy_c) saw_busy = 1'b1;
        end
        tests_run++;
        if (saw_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midread_no_autostart: got busy=%b expected 0", saw_busy);
        end
        start_c = 1'b1;
        @(negedge clock);
        start_c = 1'b0;
        wait_done(2, 30, cyc);
        tests_run++;
        if (cyc !== 6) begin
            tests_failed++;
            $display("FAIL midread_rerun_latency: got %0d expected 6", cyc);
        end
        tests_run++;
        if ({id_ok_c, ts_ok_c, to_c} !== 3'b110 || id_val_c !== EXP_ID || ts_val_c !== EXP_TS) begin
            tests_failed++;
            $display("FAIL midread_rerun_result: got %b %h %h expected 110 %h %h",
                     {id_ok_c, ts_ok_c, to_c}, id_val_c, ts_val_c, EXP_ID, EXP_TS);
        end
    endtask

    initial begin
        test_reset();
        test_auto_start();
        test_ts_mismatch();
        test_wait_stall();
        test_back_to_back();
        test_timeout();
        test_latency();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
